// File: rtl/ram_arbiter.sv
// Shares one RAM between the Z80 CPU and a secondary req/ack bus master with round-robin grant.
// Optional stall statistics (cpu_stall_cnt, stats_clr) are built when RAM_ARBITER_STATS_EN is defined.
module ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
`ifdef RAM_ARBITER_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       cpu_stall_cnt,
`endif
    input  logic              cpu_ram_cs,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_wait_n,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_LAT   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int CNT_W = 3;

    logic [1:0]        state_r;
    logic              owner_r;
    logic              last_grant_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  lat_cnt_r;
    logic              cpu_served_r;
    logic [DATA_W-1:0] cpu_data_r;
    logic [DATA_W-1:0] dma_rdata_r;
    logic              dma_ack_r;
    logic              ram_en_r;
    logic              ram_we_r;

    logic              cpu_pend_s;
    logic              dma_pend_s;
    logic              grant_s;
    logic              grant_own_s;
    logic              lat_last_s;

    // Reset gates the pending term so WAIT_n reads released while rst_n_i is low.
    assign cpu_pend_s = rst_n_i & cpu_ram_cs & (~cpu_rd_n | ~cpu_wr_n) & ~cpu_served_r;
    assign dma_pend_s = dma_req;
    assign lat_last_s = (lat_cnt_r == {CNT_W{1'b0}});

    assign cpu_wait_n = ~cpu_pend_s;
    assign cpu_data_o = cpu_data_r;
    assign dma_ack    = dma_ack_r;
    assign dma_rdata  = dma_rdata_r;
    assign ram_en     = ram_en_r;
    assign ram_we     = ram_we_r;
    assign ram_addr   = addr_r;
    assign ram_wdata  = wdata_r;

    // Round-robin arbitration: on a tie the master that was not served last wins.
    always_comb begin
        grant_s     = 1'b0;
        grant_own_s = OWN_CPU;
        if (cpu_pend_s && dma_pend_s) begin
            grant_s     = 1'b1;
            grant_own_s = (last_grant_r == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (cpu_pend_s) begin
            grant_s     = 1'b1;
            grant_own_s = OWN_CPU;
        end else if (dma_pend_s) begin
            grant_s     = 1'b1;
            grant_own_s = OWN_DMA;
        end else begin
            grant_s     = 1'b0;
            grant_own_s = OWN_CPU;
        end
    end

    // Access sequencer: IDLE -> ISSUE -> LAT (RAM_LAT cycles) -> DONE, with registered RAM strobes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CPU;
            last_grant_r <= OWN_DMA;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            lat_cnt_r    <= {CNT_W{1'b0}};
            cpu_served_r <= 1'b0;
            cpu_data_r   <= {DATA_W{1'b0}};
            dma_rdata_r  <= {DATA_W{1'b0}};
            dma_ack_r    <= 1'b0;
            ram_en_r     <= 1'b0;
            ram_we_r     <= 1'b0;
        end else begin
            ram_en_r  <= 1'b0;
            ram_we_r  <= 1'b0;
            dma_ack_r <= 1'b0;
            if (!cpu_ram_cs) begin
                cpu_served_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_r  <= grant_own_s;
                        ram_en_r <= 1'b1;
                        state_r  <= ST_ISSUE;
                        if (grant_own_s == OWN_CPU) begin
                            addr_r   <= cpu_addr;
                            wdata_r  <= cpu_data_i;
                            we_r     <= ~cpu_wr_n;
                            ram_we_r <= ~cpu_wr_n;
                        end else begin
                            addr_r   <= dma_addr;
                            wdata_r  <= dma_wdata;
                            we_r     <= dma_we;
                            ram_we_r <= dma_we;
                        end
                    end
                end
                ST_ISSUE: begin
                    lat_cnt_r <= CNT_W'(RAM_LAT - 1);
                    state_r   <= ST_LAT;
                end
                ST_LAT: begin
                    if (lat_last_s) begin
                        state_r <= ST_DONE;
                        if (owner_r == OWN_CPU) begin
                            if (!we_r) begin
                                cpu_data_r <= ram_rdata;
                            end
                            // A CPU that abandoned its bus cycle must not be marked served.
                            if (cpu_ram_cs) begin
                                cpu_served_r <= 1'b1;
                            end
                        end else begin
                            if (!we_r) begin
                                dma_rdata_r <= ram_rdata;
                            end
                            dma_ack_r <= 1'b1;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    last_grant_r <= owner_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_ARBITER_STATS_EN
    logic [15:0] stall_cnt_r;

    assign cpu_stall_cnt = stall_cnt_r;

    // Saturating count of CPU wait cycles; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= 16'h0000;
        end else if (stats_clr) begin
            stall_cnt_r <= 16'h0000;
        end else if (!cpu_wait_n && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: instance a uses RAM_LAT=1, instance b uses RAM_LAT=3.
// Both share stimulus; each has its own behavioural RAM with matching latency.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_ram_cs, cpu_rd_n, cpu_wr_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_i;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
`ifdef RAM_ARBITER_STATS_EN
    logic        stats_clr;
    logic [15:0] cnt_a, cnt_b;
`endif

    logic [7:0]  cpu_data_a, dma_rdata_a, ram_wdata_a, ram_rdata_a;
    logic        wait_a, ack_a, en_a, we_a;
    logic [15:0] addr_a;
    logic [7:0]  cpu_data_b, dma_rdata_b, ram_wdata_b, ram_rdata_b;
    logic        wait_b, ack_b, en_b, we_b;
    logic [15:0] addr_b;

    logic [7:0]  mem_a [65536];
    logic [7:0]  mem_b [65536];
    logic [7:0]  rd_a;
    logic [7:0]  pipe_b [3];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;
    int          en_cnt_a = 0;
    int          en0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
`ifdef RAM_ARBITER_STATS_EN
        .stats_clr(stats_clr), .cpu_stall_cnt(cnt_a),
`endif
        .cpu_ram_cs(cpu_ram_cs), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_a),
        .cpu_wait_n(wait_a), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(ack_a), .dma_rdata(dma_rdata_a),
        .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a)
    );

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(3)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
`ifdef RAM_ARBITER_STATS_EN
        .stats_clr(stats_clr), .cpu_stall_cnt(cnt_b),
`endif
        .cpu_ram_cs(cpu_ram_cs), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_b),
        .cpu_wait_n(wait_b), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(ack_b), .dma_rdata(dma_rdata_b),
        .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b)
    );

    // RAM model with one cycle of read latency, plus a preload port for the bench.
    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_addr] <= pl_data;
        end else if (en_a && we_a) begin
            mem_a[addr_a] <= ram_wdata_a;
        end
        if (en_a && !we_a) begin
            rd_a <= mem_a[addr_a];
        end
        if (en_a) begin
            en_cnt_a <= en_cnt_a + 1;
        end
    end
    assign ram_rdata_a = rd_a;

    // RAM model with three cycles of read latency.
    always @(posedge clk) begin
        if (pl_en) begin
            mem_b[pl_addr] <= pl_data;
        end else if (en_b && we_b) begin
            mem_b[addr_b] <= ram_wdata_b;
        end
        if (en_b && !we_b) begin
            pipe_b[0] <= mem_b[addr_b];
        end
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign ram_rdata_b = pipe_b[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        cpu_addr = 16'h0000; cpu_data_i = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
`ifdef RAM_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        preload(16'h1234, 8'hA5);
        preload(16'h0100, 8'h5A);
        preload(16'h0010, 8'h11);

        // Reset values
        #1;
        chk("rst_wait_a", wait_a, 1); chk("rst_en_a", en_a, 0); chk("rst_ack_a", ack_a, 0);
        chk("rst_addr_a", addr_a, 0); chk("rst_data_a", cpu_data_a, 0);
        chk("rst_wait_b", wait_b, 1); chk("rst_ack_b", ack_b, 0);
        tick(); rst_n = 1'b1;
        tick();

        // CPU read of 0x1234 (latency 1)
        tick(); cpu_ram_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h1234; en0 = en_cnt_a; #1;
        chk("rd_c0_wait", wait_a, 0); chk("rd_c0_en", en_a, 0);
        tick(); #1;
        chk("rd_c1_en", en_a, 1); chk("rd_c1_addr", addr_a, 16'h1234); chk("rd_c1_we", we_a, 0);
        chk("rd_c1_wait", wait_a, 0);
        tick(); #1;
        chk("rd_c2_en", en_a, 0); chk("rd_c2_wait", wait_a, 0);
        tick(); #1;
        chk("rd_c3_wait", wait_a, 1); chk("rd_c3_data", cpu_data_a, 8'hA5);
        tick(); tick(); tick(); #1;
        chk("rd_hold_wait", wait_a, 1); chk("rd_one_en", en_cnt_a - en0, 1);
        cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1;
        tick(); tick(); tick();

        // CPU write 0x3C to 0x8000
        tick(); cpu_ram_cs = 1'b1; cpu_wr_n = 1'b0; cpu_addr = 16'h8000; cpu_data_i = 8'h3C; #1;
        chk("wr_c0_wait", wait_a, 0);
        tick(); #1;
        chk("wr_c1_en", en_a, 1); chk("wr_c1_we", we_a, 1);
        chk("wr_c1_addr", addr_a, 16'h8000); chk("wr_c1_wdata", ram_wdata_a, 8'h3C);
        tick(); #1;
        chk("wr_c2_wait", wait_a, 0); chk("wr_c2_en", en_a, 0);
        tick(); #1;
        chk("wr_c3_wait", wait_a, 1);
        tick(); cpu_ram_cs = 1'b0; cpu_wr_n = 1'b1; #1;
        chk("wr_mem", mem_a[16'h8000], 8'h3C);
        tick(); tick(); tick(); tick();

        // DMA read of 0x0100 (b: latency 3, a: latency 1)
        tick(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100; #1;
        chk("dma_c0_ack_b", ack_b, 0);
        tick(); tick(); tick(); #1;
        chk("dma_c3_ack_a", ack_a, 1); chk("dma_c3_rdata_a", dma_rdata_a, 8'h5A);
        chk("dma_c3_ack_b", ack_b, 0);
        tick(); #1;
        chk("dma_c4_ack_b", ack_b, 0); chk("dma_c4_ack_a", ack_a, 0);
        tick(); #1;
        chk("dma_c5_ack_b", ack_b, 1); chk("dma_c5_rdata_b", dma_rdata_b, 8'h5A);
        dma_req = 1'b0;
        tick(); #1;
        chk("dma_c6_ack_b", ack_b, 0); chk("dma_c6_hold_b", dma_rdata_b, 8'h5A);
        tick(); tick(); tick(); tick();

        // Both request together: order CPU, DMA, CPU, DMA on instance a
        tick(); cpu_ram_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h0010;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0020; dma_wdata = 8'h77; #1;
        chk("arb_c0_wait", wait_a, 0);
        tick(); #1;
        chk("arb_g1_en", en_a, 1); chk("arb_g1_we", we_a, 0); chk("arb_g1_addr", addr_a, 16'h0010);
        tick();
        tick(); #1;
        chk("arb_c3_wait", wait_a, 1); chk("arb_c3_data", cpu_data_a, 8'h11);
        cpu_ram_cs = 1'b0;
        tick(); cpu_ram_cs = 1'b1; #1;
        chk("arb_c4_wait", wait_a, 0);
        tick(); #1;
        chk("arb_g2_en", en_a, 1); chk("arb_g2_we", we_a, 1); chk("arb_g2_addr", addr_a, 16'h0020);
        chk("arb_g2_wdata", ram_wdata_a, 8'h77);
        tick();
        tick(); #1;
        chk("arb_c7_ack", ack_a, 1); chk("arb_c7_wait", wait_a, 0);
        tick();
        tick(); #1;
        chk("arb_g3_en", en_a, 1); chk("arb_g3_we", we_a, 0); chk("arb_g3_addr", addr_a, 16'h0010);
        tick();
        tick(); #1;
        chk("arb_c11_wait", wait_a, 1);
        cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1;
        tick();
        tick(); #1;
        chk("arb_g4_en", en_a, 1); chk("arb_g4_we", we_a, 1); chk("arb_g4_addr", addr_a, 16'h0020);
        dma_req = 1'b0;
        tick();
        tick(); #1;
        chk("dma_drop_ack", ack_a, 1);
        tick(); #1;
        chk("dma_drop_noack", ack_a, 0);
        repeat (6) tick();

        // CPU drops cs mid-access: data still captured, not marked served
        tick(); cpu_ram_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h0100; #1;
        chk("csd_c0_wait", wait_a, 0);
        tick(); cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1; #1;
        chk("csd_c1_en", en_a, 1);
        tick();
        tick(); cpu_ram_cs = 1'b1; cpu_rd_n = 1'b0; #1;
        chk("csd_c3_data", cpu_data_a, 8'h5A); chk("csd_c3_wait", wait_a, 0);
        tick(); tick(); tick(); tick(); #1;
        chk("csd_c7_wait", wait_a, 1);
        cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1;
        repeat (6) tick();

        // Reset pulse during LAT with the CPU request still held
        tick(); cpu_ram_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h1234; #1;
        chk("rml_c0_wait", wait_a, 0);
        tick();
        tick(); rst_n = 1'b0; #1;
        chk("rml_wait", wait_a, 1); chk("rml_en", en_a, 0); chk("rml_ack", ack_a, 0);
        chk("rml_data", cpu_data_a, 0);
        #1 rst_n = 1'b1; #1;
        chk("rml_rel_wait", wait_a, 0);
        tick(); #1;
        chk("rml_c3_en", en_a, 1); chk("rml_c3_addr", addr_a, 16'h1234);
        tick(); #1;
        chk("rml_c4_data", cpu_data_a, 0);
        tick(); #1;
        chk("rml_c5_wait", wait_a, 1); chk("rml_c5_data", cpu_data_a, 8'hA5);
        cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1;
        repeat (6) tick();

`ifdef RAM_ARBITER_STATS_EN
        // Stall counter: one CPU read with latency 1 stalls for 3 cycles
        stats_clr = 1'b1;
        tick(); stats_clr = 1'b0; #1;
        chk("st_clr0", cnt_a, 0);
        tick(); cpu_ram_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h1234;
        tick(); tick(); tick(); #1;
        chk("st_cnt3", cnt_a, 3);
        cpu_ram_cs = 1'b0; cpu_rd_n = 1'b1; stats_clr = 1'b1;
        tick(); stats_clr = 1'b0; #1;
        chk("st_clr1", cnt_a, 0);
        repeat (4) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single on-chip RAM between the Z80 CPU and a secondary bus master (DMA/video fetch).
- Sits between the address decoder's ram_cs output and the RAM macro.
- Stalls the CPU with WAIT_n while an access is outstanding or the RAM is busy.
- Serves the secondary master through a req/ack handshake; a round-robin grant prevents starvation.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, data width
RAM_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata; legal range 1..4

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; one clock, asynchronous assert, active-low
cpu_ram_cs  in  1  RAM select from the address decoder, held for the whole CPU bus cycle
cpu_rd_n  in  1  Z80 RD_n
cpu_wr_n  in  1  Z80 WR_n
cpu_addr  in  ADDR_W  Z80 address
cpu_data_i  in  DATA_W  Z80 write data
cpu_data_o  out  DATA_W  registered read data to the CPU
cpu_wait_n  out  1  Z80 WAIT_n
dma_req  in  1  secondary master request; held with addr/data stable until ack
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  secondary master address
dma_wdata  in  DATA_W  secondary master write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DATA_W  registered read data; valid when dma_ack=1 and held until the next DMA completion
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset values:
  - All outputs 0 except cpu_wait_n=1.
  - state=IDLE, last_grant=DMA, so the CPU wins the first tie.
  - cpu_served=0, internal counter=0.
- CPU pending (combinational): cpu_ram_cs & (~cpu_rd_n | ~cpu_wr_n) & ~cpu_served.
- cpu_wait_n: combinational, equal to ~CPU pending. It must fall in the same cycle the request appears, to meet Z80 T2 sampling.
- cpu_served:
  - Set on the edge entering DONE for a CPU access.
  - Cleared on any edge where cpu_ram_cs=0.
  - Together these give exactly one RAM access per CPU bus cycle.
- FSM states: IDLE, ISSUE, LAT, DONE.
- IDLE:
  - Arbitrate among pending requesters.
  - If both are pending, grant the one not equal to last_grant. Otherwise grant the single requester.
  - On a grant: latch owner, addr, wdata and we, then go to ISSUE.
  - CPU write iff cpu_wr_n=0.
- ISSUE (1 cycle): ram_en=1, ram_we=latched we; ram_addr/ram_wdata are driven from the latched values. Go to LAT.
- LAT (RAM_LAT cycles, counted down): ram_en=0. On the final LAT edge, capture ram_rdata into cpu_data_o or dma_rdata by owner, and go to DONE.
  - Writes also pass through LAT; captured data is ignored.
- DONE (1 cycle):
  - DMA owner: dma_ack=1.
  - CPU owner: cpu_served=1, so cpu_wait_n=1 and cpu_data_o is valid.
  - Update last_grant. Return to IDLE.
- Latency from request seen in IDLE to DONE: RAM_LAT+2 cycles. One access completes every RAM_LAT+3 cycles.
- Boundary conditions:
  - cpu_ram_cs drops mid-access: the RAM access still completes, cpu_data_o is updated, and cpu_served stays 0.
  - dma_req drops before ack (protocol violation): the access completes and dma_ack still pulses.
  - dma_req held high after ack: treated as a new request on the next IDLE (burst). Round-robin forces alternation with a pending CPU.
  - Reset mid-access: immediate return to reset values. An in-flight write may or may not have reached the RAM.
- No combinational path from ram_rdata to any output.

Optional Feature:
- Macro: RAM_ARBITER_STATS_EN.
- When defined:
  - Adds output cpu_stall_cnt (16 bits) and input stats_clr (1 bit).
  - Counter increments every cycle with cpu_wait_n=0 and saturates at 16'hFFFF.
  - stats_clr=1 clears it synchronously; clear has priority over increment.
  - Reset value 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- CPU read, RAM_LAT=1, RAM[0x1234]=0xA5: cpu_ram_cs=1, cpu_rd_n=0 at cycle 0 -> cpu_wait_n low cycles 0-2; ram_en=1 in cycle 1 only; cpu_wait_n=1 and cpu_data_o=0xA5 from cycle 3; exactly one ram_en while cs stays high.
- CPU write 0x3C to 0x8000 -> single cycle with ram_en=1, ram_we=1, ram_addr=0x8000, ram_wdata=0x3C; cpu_wait_n released after RAM_LAT+2 cycles.
- DMA read, RAM[0x0100]=0x5A, RAM_LAT=3 -> dma_ack pulses for one cycle, 5 cycles after dma_req rises; dma_rdata=0x5A.
- CPU and DMA both request in the same IDLE cycle after reset -> CPU is served first. Holding both continuously produces the grant order CPU, DMA, CPU, DMA.
- rst_n_i pulsed low during LAT -> cpu_wait_n=1, dma_ack=0, ram_en=0 immediately; the FSM restarts in IDLE and re-serves the still-held CPU request.
- RAM_ARBITER_STATS_EN: DMA burst stalls the CPU for 7 cycles -> cpu_stall_cnt=7; stats_clr for 1 cycle -> 0.
